// File: rtl/tms_prog_loader.sv
// Wishbone loader for the TMS1x00 program RAM: 32-bit words <-> 4 byte accesses; ROM write acks 5 cycles after stb, read 6, CTRL/other 1.
// No stall input on the RAM side; a master dropping cyc/stb mid-word aborts it without ack; RUN=1 hands the RAM port to the core.
module tms_prog_loader #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          ROM_AW   = 11
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ROM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              cpu_fetch,
  input  logic [ROM_AW-1:0] cpu_pc,
  output logic [7:0]        cpu_instr,
  output logic              cpu_instr_valid,
  output logic              cpu_rst_n
);

  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [ROM_AW-3:0] word_q;
  logic [31:0]       wdat_q;
  logic [3:0]        sel_q;
  logic [31:0]       rdat_q;
  logic              run, err, fetch_q;

  logic live, req, rom_hit, ctrl_hit;

  assign live     = wbs_cyc_i & wbs_stb_i;
  assign req      = live & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
  assign rom_hit  = ~wbs_adr_i[11];
  assign ctrl_hit = (wbs_adr_i[11:0] == 12'h800);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) begin
        if (rom_hit && !run) state_nxt = wbs_we_i ? WR : RD;
        else                 state_nxt = ACK;
      end
      WR: begin
        if (!live)              state_nxt = IDLE;
        else if (cnt == 3'd3)   state_nxt = ACK;
      end
      RD: begin
        if (!live)              state_nxt = IDLE;
        else if (cnt == 3'd4)   state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and CTRL register; read bytes land one cycle after their issue.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      word_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      run     <= 1'b0;
      err     <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      fetch_q <= run & cpu_fetch;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            word_q <= wbs_adr_i[ROM_AW-1:2];
            wdat_q <= wbs_dat_i;
            sel_q  <= wbs_sel_i;
            rdat_q <= (ctrl_hit && !wbs_we_i) ? {30'd0, err, run} : 32'd0;
            if (rom_hit && run) err <= 1'b1;
            if (ctrl_hit && wbs_we_i && wbs_sel_i[0]) begin
              run <= wbs_dat_i[0];
              if (wbs_dat_i[1]) err <= 1'b0;
            end
          end
        end
        WR: cnt <= cnt + 3'd1;
        RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) rdat_q[{cnt[1:0] - 2'd1, 3'b000} +: 8] <= mem_rdata;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    wbs_ack_o = (state == ACK);
    wbs_dat_o = (state == ACK) ? rdat_q : 32'd0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (run) begin
      mem_en   = cpu_fetch;
      mem_addr = cpu_pc;
    end else begin
      case (state)
        WR: begin
          mem_en    = live;
          mem_we    = live & sel_q[cnt[1:0]];
          mem_addr  = {word_q, cnt[1:0]};
          mem_wdata = wdat_q[{cnt[1:0], 3'b000} +: 8];
        end
        RD: begin
          mem_en   = live & ~cnt[2];
          mem_addr = {word_q, cnt[1:0]};
        end
        default: ;
      endcase
    end
  end

  assign cpu_instr       = mem_rdata;
  assign cpu_instr_valid = fetch_q & run;
  assign cpu_rst_n       = run;

endmodule
